// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module      : life_pkg
// Description : Shared FSM states, rule constants and row population helper
//               for the Game of Life engine.
// Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

    localparam int GEN_W = 16;

    localparam logic [3:0] c_rule_survive = 4'd2;
    localparam logic [3:0] c_rule_birth   = 4'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMMIT  = 2'd2
    } life_state_t;

    function automatic logic [6:0] row_popcount(input logic [63:0] row);
        logic [6:0] count;
        count = '0;
        for (int i = 0; i < 64; i++) begin
            count = count + 7'(row[i]);
        end
        return count;
    endfunction

endpackage
`default_nettype wire

// File: rtl/life_row_rule.sv
`default_nettype none
// ============================================================================
// Module      : life_row_rule
// Description : Combinational next-state of one grid row from its three rows.
// Revision    : 1.0 - initial release
// ============================================================================
module life_row_rule
    import life_pkg::*;
#(
    parameter int GRID_W = 32,
    parameter int WRAP   = 1
) (
    input  logic [GRID_W-1:0] above,
    input  logic [GRID_W-1:0] mid,
    input  logic [GRID_W-1:0] below,
    output logic [GRID_W-1:0] next_row
);

    // *_l[x] carries column x-1, *_r[x] carries column x+1
    logic [GRID_W-1:0] w_a_l, w_a_r, w_m_l, w_m_r, w_b_l, w_b_r;

    assign w_a_l = {above[GRID_W-2:0], (WRAP != 0) ? above[GRID_W-1] : 1'b0};
    assign w_a_r = {(WRAP != 0) ? above[0] : 1'b0, above[GRID_W-1:1]};
    assign w_m_l = {mid[GRID_W-2:0],   (WRAP != 0) ? mid[GRID_W-1]   : 1'b0};
    assign w_m_r = {(WRAP != 0) ? mid[0] : 1'b0,   mid[GRID_W-1:1]};
    assign w_b_l = {below[GRID_W-2:0], (WRAP != 0) ? below[GRID_W-1] : 1'b0};
    assign w_b_r = {(WRAP != 0) ? below[0] : 1'b0, below[GRID_W-1:1]};

    for (genvar x = 0; x < GRID_W; x++) begin : g_col
        logic [3:0] w_count;
        assign w_count = 4'(w_a_l[x]) + 4'(above[x]) + 4'(w_a_r[x])
                       + 4'(w_m_l[x])                + 4'(w_m_r[x])
                       + 4'(w_b_l[x]) + 4'(below[x]) + 4'(w_b_r[x]);
        assign next_row[x] = (w_count == c_rule_birth) ||
                             (mid[x] && (w_count == c_rule_survive));
    end

endmodule
`default_nettype wire

// File: rtl/life_engine.sv
`default_nettype none
// ============================================================================
// Module      : life_engine
// Description : Double-buffered Game of Life, one row per cycle. Optional
//               population output enabled by macro LIFE_POPCOUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module life_engine
    import life_pkg::*;
#(
    parameter int GRID_W = 32,
    parameter int GRID_H = 24,
    parameter int WRAP   = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      step,
    input  logic                      run,
    input  logic                      tick,
    input  logic                      edit_valid,
    output logic                      edit_ready,
    input  logic [$clog2(GRID_W)-1:0] edit_x,
    input  logic [$clog2(GRID_H)-1:0] edit_y,
    input  logic                      edit_value,
    input  logic [$clog2(GRID_W)-1:0] read_x,
    input  logic [$clog2(GRID_H)-1:0] read_y,
    output logic                      read_cell,
    output logic                      busy,
    output logic                      done,
    output logic [GEN_W-1:0]          generation
`ifdef LIFE_POPCOUNT_EN
    ,
    output logic [$clog2(GRID_W*GRID_H+1)-1:0] population
`endif
);

    localparam int c_y_w = $clog2(GRID_H);
    localparam logic [c_y_w-1:0] c_last_row = c_y_w'(GRID_H - 1);
    localparam logic [c_y_w-1:0] c_row_one  = c_y_w'(1);

    function automatic logic [GRID_H-1:0][GRID_W-1:0] glider_seed();
        logic [GRID_H-1:0][GRID_W-1:0] g;
        g = '0;
        g[0][1] = 1'b1;
        g[1][2] = 1'b1;
        g[2][0] = 1'b1;
        g[2][1] = 1'b1;
        g[2][2] = 1'b1;
        return g;
    endfunction

    localparam logic [GRID_H-1:0][GRID_W-1:0] c_seed = glider_seed();

    life_state_t                   r_state, w_state_next;
    logic                          r_sel;
    logic [c_y_w-1:0]              r_row;
    logic [GEN_W-1:0]              r_generation;
    logic                          r_read_cell;
    logic [GRID_H-1:0][GRID_W-1:0] r_buf0, r_buf1;
    logic [GRID_H-1:0][GRID_W-1:0] w_cur;
    logic                          w_edit, w_edit_hit, w_read_in_range;
    logic [c_y_w-1:0]              w_up_idx, w_dn_idx;
    logic [GRID_W-1:0]             w_above, w_mid, w_below, w_next_row;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Edits win over a start request in the same IDLE cycle
    always_comb begin
        w_state_next = r_state;
        edit_ready   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        w_edit       = 1'b0;
        case (r_state)
            IDLE: begin
                edit_ready = 1'b1;
                w_edit     = edit_valid;
                if (!edit_valid && (step || (run && tick))) begin
                    w_state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (r_row == c_last_row) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_cur           = r_sel ? r_buf1 : r_buf0;
    assign w_edit_hit      = w_edit && (32'(edit_x) < GRID_W) && (32'(edit_y) < GRID_H);
    assign w_read_in_range = (32'(read_x) < GRID_W) && (32'(read_y) < GRID_H);

    always_comb begin
        w_up_idx = (r_row == '0) ? c_last_row : r_row - c_row_one;
        w_dn_idx = (r_row == c_last_row) ? '0 : r_row + c_row_one;
        w_mid    = w_cur[r_row];
        w_above  = ((r_row == '0) && (WRAP == 0)) ? '0 : w_cur[w_up_idx];
        w_below  = ((r_row == c_last_row) && (WRAP == 0)) ? '0 : w_cur[w_dn_idx];
    end

    life_row_rule #(
        .GRID_W (GRID_W),
        .WRAP   (WRAP)
    ) u_row_rule (
        .above    (w_above),
        .mid      (w_mid),
        .below    (w_below),
        .next_row (w_next_row)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_buf0 <= c_seed;
            r_buf1 <= '0;
        end else begin
            if (w_edit_hit) begin
                if (r_sel) r_buf1[edit_y][edit_x] <= edit_value;
                else       r_buf0[edit_y][edit_x] <= edit_value;
            end
            if (r_state == COMPUTE) begin
                if (r_sel) r_buf0[r_row] <= w_next_row;
                else       r_buf1[r_row] <= w_next_row;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_row        <= '0;
            r_sel        <= 1'b0;
            r_generation <= '0;
            r_read_cell  <= 1'b0;
        end else begin
            if (r_state == COMPUTE) begin
                r_row <= (r_row == c_last_row) ? '0 : r_row + c_row_one;
            end
            if (r_state == COMMIT) begin
                r_sel        <= ~r_sel;
                r_generation <= r_generation + GEN_W'(1);
            end
            r_read_cell <= w_read_in_range & w_cur[read_y][read_x];
        end
    end

    assign read_cell  = r_read_cell;
    assign generation = r_generation;

`ifdef LIFE_POPCOUNT_EN
    localparam int c_pop_w = $clog2(GRID_W*GRID_H+1);

    logic [c_pop_w-1:0] r_pop_acc, r_population;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pop_acc    <= '0;
            r_population <= c_pop_w'(5);
        end else if (r_state == COMPUTE) begin
            r_pop_acc <= r_pop_acc + c_pop_w'(row_popcount(64'(w_next_row)));
        end else if (r_state == COMMIT) begin
            r_population <= r_pop_acc;
            r_pop_acc    <= '0;
        end
    end

    assign population = r_population;
`endif

endmodule
`default_nettype wire

// File: tb/tb_life_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_engine
// Description : Randomised self-checking bench; a wrapping and a flat engine
//               share stimulus. Population checked when LIFE_POPCOUNT_EN set.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_life_engine;
    import life_pkg::*;

    localparam int W  = 32;
    localparam int H  = 24;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic clock = 1'b0, reset_n = 1'b1;
    logic step = 1'b0, run = 1'b0, tick = 1'b0;
    logic edit_valid = 1'b0, edit_value = 1'b0;
    logic [XW-1:0] edit_x = '0, read_x = '0;
    logic [YW-1:0] edit_y = '0, read_y = '0;

    logic edit_ready_w, read_cell_w, busy_w, done_w;
    logic edit_ready_n, read_cell_n, busy_n, done_n;
    logic [GEN_W-1:0] generation_w, generation_n;
`ifdef LIFE_POPCOUNT_EN
    localparam int PW = $clog2(W*H+1);
    logic [PW-1:0] population_w, population_n;
`endif

    int vectors = 0, miscompares = 0, exp_gen = 0;
    bit   m_w[H][W], m_n[H][W];
    logic img_w[H][W], img_n[H][W];

    always #5 clock = ~clock;

    life_engine #(.GRID_W(W), .GRID_H(H), .WRAP(1)) u_dut_wrap (
        .clock(clock), .reset_n(reset_n), .step(step), .run(run), .tick(tick),
        .edit_valid(edit_valid), .edit_ready(edit_ready_w), .edit_x(edit_x),
        .edit_y(edit_y), .edit_value(edit_value), .read_x(read_x), .read_y(read_y),
        .read_cell(read_cell_w), .busy(busy_w), .done(done_w), .generation(generation_w)
`ifdef LIFE_POPCOUNT_EN
        , .population(population_w)
`endif
    );

    life_engine #(.GRID_W(W), .GRID_H(H), .WRAP(0)) u_dut_flat (
        .clock(clock), .reset_n(reset_n), .step(step), .run(run), .tick(tick),
        .edit_valid(edit_valid), .edit_ready(edit_ready_n), .edit_x(edit_x),
        .edit_y(edit_y), .edit_value(edit_value), .read_x(read_x), .read_y(read_y),
        .read_cell(read_cell_n), .busy(busy_n), .done(done_n), .generation(generation_n)
`ifdef LIFE_POPCOUNT_EN
        , .population(population_n)
`endif
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                m_w[y][x] = 1'b0;
                m_n[y][x] = 1'b0;
            end
        m_w[0][1] = 1'b1; m_w[1][2] = 1'b1; m_w[2][0] = 1'b1; m_w[2][1] = 1'b1; m_w[2][2] = 1'b1;
        m_n[0][1] = 1'b1; m_n[1][2] = 1'b1; m_n[2][0] = 1'b1; m_n[2][1] = 1'b1; m_n[2][2] = 1'b1;
        exp_gen = 0;
    endtask

    // Neighbour counts straight from the rules: torus for m_w, dead border for m_n
    task automatic model_step();
        bit tw[H][W];
        bit tn[H][W];
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                int nw = 0;
                int nn = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++) begin
                        int yy = y + dy;
                        int xx = x + dx;
                        if (dy == 0 && dx == 0) continue;
                        nw += int'(m_w[(yy + H) % H][(xx + W) % W]);
                        if (yy >= 0 && yy < H && xx >= 0 && xx < W) nn += int'(m_n[yy][xx]);
                    end
                tw[y][x] = (nw == 3) || (m_w[y][x] && nw == 2);
                tn[y][x] = (nn == 3) || (m_n[y][x] && nn == 2);
            end
        m_w = tw;
        m_n = tn;
        exp_gen++;
    endtask

    function automatic int diff_w();
        int d = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (img_w[y][x] !== logic'(m_w[y][x])) d++;
        return d;
    endfunction

    function automatic int diff_n();
        int d = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (img_n[y][x] !== logic'(m_n[y][x])) d++;
        return d;
    endfunction

    function automatic int img_pop_w();
        int c = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (img_w[y][x] === 1'b1) c++;
        return c;
    endfunction

    function automatic int img_pop_n();
        int c = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (img_n[y][x] === 1'b1) c++;
        return c;
    endfunction

`ifdef LIFE_POPCOUNT_EN
    function automatic int model_pop_w();
        int c = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) c += int'(m_w[y][x]);
        return c;
    endfunction

    function automatic int model_pop_n();
        int c = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) c += int'(m_n[y][x]);
        return c;
    endfunction
`endif

    task automatic scan();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                read_x = XW'(x);
                read_y = YW'(y);
                cyc();
                img_w[y][x] = read_cell_w;
                img_n[y][x] = read_cell_n;
            end
    endtask

    task automatic do_reset();
        step = 1'b0; run = 1'b0; tick = 1'b0; edit_valid = 1'b0;
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
        model_reset();
    endtask

    task automatic do_edit(input int x, input int y, input bit v);
        edit_valid = 1'b1;
        edit_x     = XW'(x);
        edit_y     = YW'(y);
        edit_value = v;
        cyc();
        edit_valid = 1'b0;
        m_w[y][x]  = v;
        m_n[y][x]  = v;
    endtask

    // Starts one generation; noise toggles step/run/tick while busy. lat = -1 on timeout.
    task automatic run_gen(input bit use_run, input bit noise, output int lat, output int busy_cnt);
        if (use_run) begin
            run  = 1'b1;
            tick = 1'b1;
        end else begin
            step = 1'b1;
        end
        cyc();
        step = 1'b0; run = 1'b0; tick = 1'b0;
        lat      = 1;
        busy_cnt = (busy_w === 1'b1) ? 1 : 0;
        while (done_w !== 1'b1 && lat < 200) begin
            if (noise) begin
                step = 1'($urandom);
                run  = 1'($urandom);
                tick = 1'($urandom);
            end
            cyc();
            lat++;
            if (busy_w === 1'b1) busy_cnt++;
        end
        step = 1'b0; run = 1'b0; tick = 1'b0;
        if (done_w !== 1'b1) lat = -1;
        cyc();
        if (busy_w === 1'b1) busy_cnt++;
        model_step();
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        cyc();
        cyc();
        vectors++;
        if (busy_w !== 1'b0 || done_w !== 1'b0 || generation_w !== '0 || read_cell_w !== 1'b0 ||
            edit_ready_w !== 1'b1 || busy_n !== 1'b0 || generation_n !== '0 || read_cell_n !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b gen=%0d read_cell=%b edit_ready=%b flat_busy=%b flat_gen=%0d, required 0 0 0 0 1 0 0",
                     busy_w, done_w, generation_w, read_cell_w, edit_ready_w, busy_n, generation_n);
        end
        reset_n = 1'b1;
        cyc();
        model_reset();
        scan();
        vectors++;
        if (diff_w() != 0 || diff_n() != 0) begin
            miscompares++;
            $display("FAIL reset_grid: %0d/%0d cells differ, required 0/0", diff_w(), diff_n());
        end
`ifdef LIFE_POPCOUNT_EN
        vectors++;
        if (population_w !== PW'(5)) begin
            miscompares++;
            $display("FAIL reset_population: got %0d, required 5", population_w);
        end
`endif
        read_x = XW'(1);
        read_y = YW'(H);
        cyc();
        vectors++;
        if (read_cell_w !== 1'b0 || read_cell_n !== 1'b0) begin
            miscompares++;
            $display("FAIL read_out_of_range: got %b/%b, required 0/0", read_cell_w, read_cell_n);
        end
    endtask

    task automatic test_single_step();
        int lat, bc;
        run_gen(1'b0, 1'b0, lat, bc);
        vectors++;
        if (lat != H + 1) begin
            miscompares++;
            $display("FAIL step_latency: got %0d, required %0d", lat, H + 1);
        end
        vectors++;
        if (bc != H + 1) begin
            miscompares++;
            $display("FAIL busy_cycles: got %0d, required %0d", bc, H + 1);
        end
        vectors++;
        if (generation_w !== GEN_W'(exp_gen) || done_w !== 1'b0) begin
            miscompares++;
            $display("FAIL step_generation: gen=%0d done=%b, required gen=%0d done=0", generation_w, done_w, exp_gen);
        end
        scan();
        vectors++;
        if (diff_w() != 0 || diff_n() != 0) begin
            miscompares++;
            $display("FAIL step_grid: %0d/%0d cells differ, required 0/0", diff_w(), diff_n());
        end
        vectors++;
        if (img_w[1][0] !== 1'b1 || img_w[1][2] !== 1'b1 || img_w[2][1] !== 1'b1 ||
            img_w[2][2] !== 1'b1 || img_w[3][1] !== 1'b1 || img_pop_w() != 5) begin
            miscompares++;
            $display("FAIL glider_gen1: live cells=%0d, required 5 at (0,1)(2,1)(1,2)(2,2)(1,3)", img_pop_w());
        end
    endtask

    task automatic test_four_steps();
        int lat, bc, bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            run_gen(1'(i % 2), 1'b1, lat, bc);
            if (lat != H + 1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL four_latency: %0d generations off, required 0", bad);
        end
        vectors++;
        if (generation_w !== GEN_W'(4)) begin
            miscompares++;
            $display("FAIL four_generation: got %0d, required 4", generation_w);
        end
        scan();
        vectors++;
        if (diff_w() != 0 || diff_n() != 0) begin
            miscompares++;
            $display("FAIL four_grid: %0d/%0d cells differ, required 0/0", diff_w(), diff_n());
        end
        vectors++;
        if (img_w[1][2] !== 1'b1 || img_w[2][3] !== 1'b1 || img_w[3][1] !== 1'b1 ||
            img_w[3][2] !== 1'b1 || img_w[3][3] !== 1'b1 || img_pop_w() != 5) begin
            miscompares++;
            $display("FAIL glider_translate: live cells=%0d, required glider shifted by (+1,+1)", img_pop_w());
        end
`ifdef LIFE_POPCOUNT_EN
        vectors++;
        if (population_w !== PW'(5)) begin
            miscompares++;
            $display("FAIL four_population: got %0d, required 5", population_w);
        end
`endif
    endtask

    task automatic test_blinker();
        int lat, bc;
        do_reset();
        do_edit(1, 0, 1'b0); do_edit(2, 1, 1'b0); do_edit(0, 2, 1'b0);
        do_edit(1, 2, 1'b0); do_edit(2, 2, 1'b0);
        do_edit(10, 0, 1'b1); do_edit(11, 0, 1'b1); do_edit(12, 0, 1'b1);
        run_gen(1'b0, 1'b0, lat, bc);
        scan();
        vectors++;
        if (diff_w() != 0 || diff_n() != 0) begin
            miscompares++;
            $display("FAIL blinker_grid: %0d/%0d cells differ, required 0/0", diff_w(), diff_n());
        end
        vectors++;
        if (img_w[H-1][11] !== 1'b1 || img_w[0][11] !== 1'b1 || img_w[1][11] !== 1'b1 || img_pop_w() != 3) begin
            miscompares++;
            $display("FAIL blinker_wrap: live=%0d, required 3 at (11,%0d)(11,0)(11,1)", img_pop_w(), H - 1);
        end
        vectors++;
        if (img_n[0][11] !== 1'b1 || img_n[1][11] !== 1'b1 || img_n[H-1][11] !== 1'b0 || img_pop_n() != 2) begin
            miscompares++;
            $display("FAIL blinker_flat: live=%0d, required 2 at (11,0)(11,1)", img_pop_n());
        end
`ifdef LIFE_POPCOUNT_EN
        vectors++;
        if (population_w !== PW'(3) || population_n !== PW'(2)) begin
            miscompares++;
            $display("FAIL blinker_population: got %0d/%0d, required 3/2", population_w, population_n);
        end
`endif
    endtask

    task automatic test_edit_priority();
        int lat, bc;
        edit_valid = 1'b1;
        edit_x     = XW'(20);
        edit_y     = YW'(15);
        edit_value = 1'b1;
        step       = 1'b1;
        cyc();
        edit_valid = 1'b0;
        step       = 1'b0;
        m_w[15][20] = 1'b1;
        m_n[15][20] = 1'b1;
        vectors++;
        if (busy_w !== 1'b0 || busy_n !== 1'b0) begin
            miscompares++;
            $display("FAIL edit_priority_busy: got %b/%b, required 0/0", busy_w, busy_n);
        end
        do_edit(21, 15, 1'b1);
        do_edit(22, 15, 1'b1);
        read_x = XW'(20);
        read_y = YW'(15);
        cyc();
        vectors++;
        if (read_cell_w !== 1'b1) begin
            miscompares++;
            $display("FAIL edit_readback: got %b, required 1", read_cell_w);
        end
        run_gen(1'b0, 1'b0, lat, bc);
        vectors++;
        if (lat != H + 1) begin
            miscompares++;
            $display("FAIL edit_step_latency: got %0d, required %0d", lat, H + 1);
        end
        scan();
        vectors++;
        if (diff_w() != 0 || diff_n() != 0) begin
            miscompares++;
            $display("FAIL edit_step_grid: %0d/%0d cells differ, required 0/0", diff_w(), diff_n());
        end
    endtask

    task automatic test_random();
        int lat, bc;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                do_edit(x, y, $urandom_range(0, 99) < 35);
        for (int g = 0; g < 8; g++) begin
            run_gen(1'($urandom), 1'b1, lat, bc);
            vectors++;
            if (lat != H + 1 || bc != H + 1) begin
                miscompares++;
                $display("FAIL random_timing g%0d: latency=%0d busy=%0d, required %0d", g, lat, bc, H + 1);
            end
            vectors++;
            if (generation_w !== GEN_W'(exp_gen) || generation_n !== GEN_W'(exp_gen)) begin
                miscompares++;
                $display("FAIL random_generation g%0d: got %0d/%0d, required %0d", g, generation_w, generation_n, exp_gen);
            end
            scan();
            vectors++;
            if (diff_w() != 0 || diff_n() != 0) begin
                miscompares++;
                $display("FAIL random_grid g%0d: %0d/%0d cells differ, required 0/0", g, diff_w(), diff_n());
            end
`ifdef LIFE_POPCOUNT_EN
            vectors++;
            if (population_w !== PW'(model_pop_w()) || population_n !== PW'(model_pop_n())) begin
                miscompares++;
                $display("FAIL random_population g%0d: got %0d/%0d, required %0d/%0d",
                         g, population_w, population_n, model_pop_w(), model_pop_n());
            end
`endif
        end
    endtask

    task automatic test_edit_during_compute();
        int bad_ready, n;
        bad_ready = 0;
        step = 1'b1;
        cyc();
        step = 1'b0;
        for (int i = 0; i < 10; i++) begin
            int ex = $urandom_range(0, W - 1);
            int ey = $urandom_range(16, 22);
            edit_valid = 1'b1;
            edit_x     = XW'(ex);
            edit_y     = YW'(ey);
            edit_value = ~m_w[ey][ex];
            cyc();
            if (edit_ready_w !== 1'b0 || edit_ready_n !== 1'b0) bad_ready++;
        end
        edit_valid = 1'b0;
        vectors++;
        if (bad_ready != 0) begin
            miscompares++;
            $display("FAIL edit_ready_busy: high in %0d busy cycles, required 0", bad_ready);
        end
        n = 0;
        while (done_w !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        vectors++;
        if (done_w !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_edit_done: done=%b after %0d cycles, required 1", done_w, n);
        end
        cyc();
        model_step();
        scan();
        vectors++;
        if (diff_w() != 0 || diff_n() != 0) begin
            miscompares++;
            $display("FAIL busy_edit_grid: %0d/%0d cells differ, required 0/0", diff_w(), diff_n());
        end
    endtask

    task automatic test_reset_mid_compute();
        step = 1'b1;
        cyc();
        step = 1'b0;
        repeat (7) cyc();
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (busy_w !== 1'b0 || busy_n !== 1'b0 || generation_w !== '0 || done_w !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_outputs: busy=%b/%b gen=%0d done=%b, required 0/0 0 0",
                     busy_w, busy_n, generation_w, done_w);
        end
        cyc();
        reset_n = 1'b1;
        cyc();
        model_reset();
        scan();
        vectors++;
        if (diff_w() != 0 || diff_n() != 0 || generation_w !== '0) begin
            miscompares++;
            $display("FAIL abort_grid: %0d/%0d cells differ gen=%0d, required 0/0 gen=0",
                     diff_w(), diff_n(), generation_w);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_four_steps();
        test_blinker();
        test_edit_priority();
        test_random();
        test_edit_during_compute();
        test_reset_mid_compute();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

endmodule
`default_nettype wire
